// File: rtl/imem_boot_loader.sv
// Boot loader: assembles a length-prefixed big-endian byte stream into 32-bit words,
// writes them into instruction memory while the CPU is stalled, then hands over to fetch.
module imem_boot_loader #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  restart,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    output logic                  cpu_stall,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wd,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam int unsigned CNT_W   = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [7:0]  MAX_LEN = 8'(DEPTH);

    typedef enum logic [2:0] {
        WAIT_LEN,
        LOAD,
        LAST,
        RUN,
        ERROR
    } state_t;

    state_t                state;
    logic [23:0]           asm_q;
    logic [1:0]            byte_cnt;
    logic [CNT_W-1:0]      n_q;
    logic [CNT_W-1:0]      word_cnt;
    logic [CNT_W-1:0]      next_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  accept;
    logic                  len_ok;

    assign accept   = rx_valid && rx_ready;
    assign len_ok   = (rx_data != 8'd0) && (rx_data <= MAX_LEN);
    assign next_cnt = word_cnt + CNT_W'(1);

    // Fetch path owns the address port once the program is running.
    assign mem_a        = (state == RUN) ? cpu_addr : addr_q;
    assign words_loaded = word_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= WAIT_LEN;
            rx_ready   <= 1'b1;
            cpu_stall  <= 1'b1;
            mem_we     <= 1'b0;
            mem_wd     <= '0;
            addr_q     <= '0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            word_cnt   <= '0;
            byte_cnt   <= '0;
            asm_q      <= '0;
            n_q        <= '0;
        end else if (restart) begin
            // Restart wins over everything, including a pending 4th byte.
            state      <= WAIT_LEN;
            rx_ready   <= 1'b1;
            cpu_stall  <= 1'b1;
            mem_we     <= 1'b0;
            addr_q     <= '0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            word_cnt   <= '0;
            byte_cnt   <= '0;
        end else begin
            mem_we <= 1'b0;
            unique case (state)
                WAIT_LEN: begin
                    if (accept) begin
                        if (len_ok) begin
                            n_q      <= CNT_W'(rx_data);
                            word_cnt <= '0;
                            byte_cnt <= '0;
                            state    <= LOAD;
                        end else begin
                            load_error <= 1'b1;
                            state      <= ERROR;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            mem_we   <= 1'b1;
                            mem_wd   <= DATA_WIDTH'({asm_q, rx_data});
                            addr_q   <= word_cnt[ADDR_WIDTH-1:0];
                            word_cnt <= next_cnt;
                            if (next_cnt == n_q) begin
                                rx_ready <= 1'b0;
                                state    <= LAST;
                            end
                        end else begin
                            asm_q <= {asm_q[15:0], rx_data};
                        end
                    end
                end
                LAST: begin
                    cpu_stall <= 1'b0;
                    load_done <= 1'b1;
                    state     <= RUN;
                end
                RUN: begin
                end
                ERROR: begin
                end
                default: state <= WAIT_LEN;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: a byte/word-level model of the loading protocol is compared
// against the DUT every cycle, plus literal checks of the logged memory writes.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        restart = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic [5:0]  cpu_addr = 6'd0;
    logic        cpu_stall;
    logic [5:0]  mem_a;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic        load_done;
    logic        load_error;
    logic [6:0]  words_loaded;

    int checks = 0;
    int errors = 0;

    imem_boot_loader #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .restart(restart),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .cpu_addr(cpu_addr), .cpu_stall(cpu_stall),
        .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd),
        .load_done(load_done), .load_error(load_error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Protocol model: tracks mode, header length and the raw data bytes received.
    localparam int M_LEN = 0, M_DATA = 1, M_LAST = 2, M_RUN = 3, M_ERR = 4;
    int          m_mode = M_LEN;
    int          m_n = 0;
    int          m_cnt = 0;
    logic [7:0]  m_buf [4];
    bit          mvalid = 0;
    bit          acc;
    logic        e_ready, e_stall, e_we, e_done, e_err;
    logic [31:0] e_wd;
    logic [5:0]  e_a;
    logic [6:0]  e_wl;

    task automatic model_step();
        if (reset) begin
            m_mode = M_LEN; m_cnt = 0;
            e_ready = 1; e_stall = 1; e_we = 0; e_wd = 0; e_a = 0;
            e_done = 0; e_err = 0; e_wl = 0;
            mvalid = 1;
        end else if (restart) begin
            m_mode = M_LEN; m_cnt = 0;
            e_ready = 1; e_stall = 1; e_we = 0; e_done = 0; e_err = 0; e_wl = 0;
        end else begin
            acc = rx_valid && e_ready;
            e_we = 0;
            case (m_mode)
                M_LEN: if (acc) begin
                    if (rx_data >= 8'd1 && rx_data <= 8'd64) begin
                        m_n = int'(rx_data); m_cnt = 0; m_mode = M_DATA;
                    end else begin
                        m_mode = M_ERR; e_err = 1;
                    end
                end
                M_DATA: if (acc) begin
                    m_buf[m_cnt % 4] = rx_data;
                    m_cnt++;
                    if (m_cnt % 4 == 0) begin
                        e_we = 1;
                        e_wd = {m_buf[0], m_buf[1], m_buf[2], m_buf[3]};
                        e_a  = 6'(m_cnt / 4 - 1);
                        e_wl = 7'(m_cnt / 4);
                        if (m_cnt == 4 * m_n) begin
                            m_mode = M_LAST; e_ready = 0;
                        end
                    end
                end
                M_LAST: begin
                    m_mode = M_RUN; e_stall = 0; e_done = 1;
                end
                default: ;
            endcase
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Every-cycle comparison against the model, plus a log of observed writes.
    logic [37:0] wq[$];
    initial forever begin
        @(negedge clk);
        if (mvalid) begin
            check("rx_ready", 64'(rx_ready), 64'(e_ready));
            check("cpu_stall", 64'(cpu_stall), 64'(e_stall));
            check("mem_we", 64'(mem_we), 64'(e_we));
            check("load_done", 64'(load_done), 64'(e_done));
            check("load_error", 64'(load_error), 64'(e_err));
            check("words_loaded", 64'(words_loaded), 64'(e_wl));
            if (e_we) begin
                check("mem_a_wr", 64'(mem_a), 64'(e_a));
                check("mem_wd_wr", 64'(mem_wd), 64'(e_wd));
            end
            if (m_mode == M_RUN) check("mem_a_run", 64'(mem_a), 64'(cpu_addr));
            if (mem_we) wq.push_back({mem_a, mem_wd});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_valid = 0;
        repeat (n) step();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit took;
        took = 0;
        if (gap > 0) idle(gap);
        rx_valid = 1;
        rx_data  = b;
        for (int t = 0; t < 20 && !took; t++) begin
            took = rx_ready;
            step();
        end
        if (!took) begin
            errors++;
            $display("FAIL send_timeout: byte %0h not accepted, expected accept", b);
        end
    endtask

    logic [7:0] txq[$];

    task automatic send_txq(input int maxgap);
        for (int i = 0; i < txq.size(); i++)
            send_byte(txq[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        txq.delete();
    endtask

    task automatic do_restart();
        restart = 1;
        step();
        restart = 0;
    endtask

    task automatic push_word(input logic [31:0] w);
        txq.push_back(w[31:24]); txq.push_back(w[23:16]);
        txq.push_back(w[15:8]);  txq.push_back(w[7:0]);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rx_ready"}, 64'(rx_ready), 64'd1);
        check({tag, "_cpu_stall"}, 64'(cpu_stall), 64'd1);
        check({tag, "_mem_we"}, 64'(mem_we), 64'd0);
        check({tag, "_mem_wd"}, 64'(mem_wd), 64'd0);
        check({tag, "_mem_a"}, 64'(mem_a), 64'd0);
        check({tag, "_load_done"}, 64'(load_done), 64'd0);
        check({tag, "_load_error"}, 64'(load_error), 64'd0);
        check({tag, "_words_loaded"}, 64'(words_loaded), 64'd0);
    endtask

    task automatic frame_t1();
        txq = '{8'h02, 8'h28, 8'h02, 8'h00, 8'h05, 8'h28, 8'h03, 8'h00, 8'h0C};
    endtask

    initial begin
        logic [37:0] e;
        step();
        step();
        check_reset_vals("reset");
        reset = 0;

        // Back-to-back N=2 frame.
        wq.delete();
        frame_t1();
        send_txq(0);
        idle(3);
        check("t1_nwrites", 64'(wq.size()), 64'd2);
        if (wq.size() == 2) begin
            check("t1_w0", 64'(wq[0]), 64'({6'd0, 32'h28020005}));
            check("t1_w1", 64'(wq[1]), 64'({6'd1, 32'h2803000C}));
        end
        check("t1_stall", 64'(cpu_stall), 64'd0);
        check("t1_done", 64'(load_done), 64'd1);
        check("t1_wl", 64'(words_loaded), 64'd2);
        cpu_addr = 6'd1;
        #1;
        check("t1_mem_a", 64'(mem_a), 64'd1);
        step();

        // Same frame with rx_valid gaps.
        do_restart();
        wq.delete();
        frame_t1();
        send_txq(3);
        idle(4);
        check("t2_nwrites", 64'(wq.size()), 64'd2);
        if (wq.size() == 2) begin
            check("t2_w0", 64'(wq[0]), 64'({6'd0, 32'h28020005}));
            check("t2_w1", 64'(wq[1]), 64'({6'd1, 32'h2803000C}));
        end

        // Illegal headers, then a legal N=1 frame.
        do_restart();
        wq.delete();
        txq = '{8'h00, 8'h11, 8'h22};
        send_txq(0);
        idle(2);
        check("t3_err0", 64'(load_error), 64'd1);
        check("t3_stall0", 64'(cpu_stall), 64'd1);
        do_restart();
        check("t3_err_clr", 64'(load_error), 64'd0);
        txq = '{8'h41};
        send_txq(0);
        idle(2);
        check("t3_err65", 64'(load_error), 64'd1);
        check("t3_nowrite", 64'(wq.size()), 64'd0);
        do_restart();
        txq = '{8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        send_txq(1);
        idle(3);
        check("t3_nwrites", 64'(wq.size()), 64'd1);
        if (wq.size() == 1) check("t3_w0", 64'(wq[0]), 64'({6'd0, 32'h11223344}));
        check("t3_done", 64'(load_done), 64'd1);

        // Restart partway through an N=3 frame.
        do_restart();
        wq.delete();
        txq = '{8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_txq(0);
        do_restart();
        idle(2);
        check("t4_nwrites", 64'(wq.size()), 64'd1);
        if (wq.size() >= 1) check("t4_w0", 64'(wq[0]), 64'({6'd0, 32'h01020304}));
        txq = '{8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_txq(0);
        idle(3);
        check("t4_nwrites2", 64'(wq.size()), 64'd2);
        if (wq.size() == 2) check("t4_w1", 64'(wq[1]), 64'({6'd0, 32'hDEADBEEF}));
        check("t4_wl", 64'(words_loaded), 64'd1);

        // Full 64-word image.
        do_restart();
        wq.delete();
        txq.push_back(8'd64);
        for (int k = 0; k < 64; k++) push_word(32'hA5000000 + 32'(k));
        send_txq(0);
        idle(4);
        check("t5_nwrites", 64'(wq.size()), 64'd64);
        for (int k = 0; k < wq.size() && k < 64; k++) begin
            e = {6'(k), 32'hA5000000 + 32'(k)};
            check("t5_word", 64'(wq[k]), 64'(e));
        end
        if (wq.size() == 64) check("t5_last", 64'(wq[63]), 64'({6'd63, 32'hA500003F}));
        check("t5_rx_ready_run", 64'(rx_ready), 64'd0);
        check("t5_wl", 64'(words_loaded), 64'd64);

        // Reset during LOAD.
        do_restart();
        txq = '{8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send_txq(0);
        rx_valid = 0;
        reset = 1;
        step();
        check_reset_vals("rst_load");
        reset = 0;

        // Reset during RUN.
        txq = '{8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
        send_txq(0);
        idle(3);
        check("t6_run_done", 64'(load_done), 64'd1);
        reset = 1;
        step();
        check_reset_vals("rst_run");
        reset = 0;

        // Restart coincident with the 4th byte of the only word.
        wq.delete();
        txq = '{8'h01, 8'hAA, 8'hBB, 8'hCC};
        send_txq(0);
        rx_valid = 1;
        rx_data  = 8'hDD;
        restart  = 1;
        step();
        restart  = 0;
        idle(3);
        check("t7_nowrite", 64'(wq.size()), 64'd0);
        check("t7_wl", 64'(words_loaded), 64'd0);
        check("t7_ready", 64'(rx_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Boot-time controller for the 64-word instruction memory. It receives a program as a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. It drives the memory write port while holding the CPU in stall, then hands the address port to the CPU fetch path and releases the stall. It sits between the host/UART receiver, the instruction memory and the fetch stage.

## Interface
Parameters:
- ADDR_WIDTH, 6, word-address width of instruction memory (depth 2^ADDR_WIDTH = 64)
- DATA_WIDTH, 32, instruction word width (fixed at 4 bytes)

Ports:
- clk  in  1  single system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- restart  in  1  request return to load mode (one-cycle pulse or level)
- rx_valid  in  1  byte available on rx_data
- rx_data  in  8  incoming byte
- rx_ready  out  1  loader accepts a byte this cycle
- cpu_addr  in  ADDR_WIDTH  fetch word address from PC
- cpu_stall  out  1  CPU must hold PC and not retire
- mem_a  out  ADDR_WIDTH  instruction memory word address
- mem_we  out  1  instruction memory write enable
- mem_wd  out  DATA_WIDTH  instruction memory write data
- load_done  out  1  program loaded, CPU running
- load_error  out  1  illegal length header received
- words_loaded  out  ADDR_WIDTH+1  number of words written in current load

## Operation
- Clock is clk; reset is synchronous and active-high. The team has decided this.
- Byte transfer occurs when rx_valid && rx_ready at a rising edge.
- Frame format: one length byte N (legal 1..64), then 4*N data bytes, most significant byte first.
- States:
  - WAIT_LEN: rx_ready=1, cpu_stall=1.
    - Legal N: latch N, clear word and byte counters, go to LOAD.
    - N=0 or N>64: go to ERROR.
  - LOAD: rx_ready=1, cpu_stall=1.
    - Bytes shift into a 24-bit assembly register. A 2-bit byte counter tracks position.
    - On the 4th byte, register mem_wd={assembly,byte} and mem_a=word index, then pulse mem_we for exactly one cycle and increment the word index.
    - When the 4th byte of word N-1 is accepted, go to LAST.
  - LAST: one cycle. mem_we=1 for the final word, rx_ready=0, cpu_stall=1. Then go to RUN.
  - RUN: rx_ready=0, cpu_stall=0, load_done=1. mem_a=cpu_addr (combinational mux), mem_we=0.
  - ERROR: load_error=1, rx_ready=1 (bytes drained and discarded), cpu_stall=1. Leaves only on restart or reset.
- restart, any state: go to WAIT_LEN next cycle and clear byte counter, word index, words_loaded, load_done and load_error.
  - A partially assembled word is discarded and never written.
  - A byte accepted in the same cycle as restart is discarded.
  - restart has priority over all other transitions, including a pending 4th byte.
- Addressing: the word index runs 0..N-1 and never wraps. For N=64 the last write is to address 63.
- words_loaded increments on each mem_we pulse. It holds its value in RUN.

## Timing
- Reset values (registered outputs, effective the edge after reset is sampled high):
  - state=WAIT_LEN, rx_ready=1, cpu_stall=1
  - mem_we=0, mem_wd=0, mem_a=0
  - load_done=0, load_error=0, words_loaded=0
- Reset mid-load behaves like restart, except all registers return to the reset values.
- Write latency: mem_we is high in the cycle after the edge that accepts the 4th byte of a word. mem_a and mem_wd are stable for that whole cycle.
- Back-to-back bytes (rx_valid held high) are accepted every cycle with no bubbles. A new write pulse occurs at most every 4 cycles.
- Gaps in rx_valid stall assembly indefinitely with no timeout.
- cpu_stall falls 2 cycles after the final byte is accepted: first the LAST cycle, then RUN.
- In the first RUN cycle, mem_a follows cpu_addr.
- cpu_stall rises in the cycle after restart is sampled.

## Test plan
- Load N=2 with bytes 02,28,02,00,05,28,03,00,0C sent back-to-back -> required response:
  - mem_we pulse at a=0 with wd=28020005, then a=1 with wd=2803000C
  - then cpu_stall=0, load_done=1, words_loaded=2
  - with cpu_addr=1, mem_a=1
- Same frame with random 0-3 cycle rx_valid gaps -> identical writes and no extra mem_we pulses.
- Header 00 -> load_error=1, cpu_stall=1, no mem_we. Restart, then header 41 (65) -> load_error=1 again. Restart, then a valid N=1 frame -> load succeeds.
- Restart after 6 data bytes of an N=3 frame -> exactly one write (word 0) before the restart. A new frame N=1 writes address 0 and gives words_loaded=1.
- N=64 with word k = 32'hA5000000+k -> 64 writes at addresses 0..63, the last with wd=A500003F. No write to address 0 after the last word, and rx_ready=0 in RUN.
- Assert reset during LOAD, and separately during RUN -> next cycle all outputs are at their reset values. Assert restart in the same cycle as the 4th byte -> no mem_we.
